// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Bundles the signals between a program-loader and its surroundings.
//   The slave side is the loader itself; the master side is whoever feeds the
//   byte stream and observes the instruction-memory bus and status.
//
//   start     master->slave  begin a load (one-cycle pulse)
//   in_data   master->slave  stream byte
//   in_valid  master->slave  in_data valid
//   in_ready  slave->master  loader accepts a byte this cycle
//   im_we     slave->master  instruction-memory write strobe (one pulse per word)
//   im_addr   slave->master  instruction-memory word address
//   im_wdata  slave->master  instruction-memory write data
//   cpu_rst   slave->master  1 = hold the MIPS core in reset
//   done      slave->master  load finished with a good checksum
//   err       slave->master  load failed (bad checksum or length overflow)
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Hardware program loader for the single-cycle MIPS core. Consumes a byte
//   stream of the form
//     N[15:8] N[7:0] { w[31:24] w[23:16] w[15:8] w[7:0] } x N  checksum
//   writes each big-endian word to instruction memory at word address 0..N-1,
//   and keeps the core in reset until the trailing XOR checksum (over the data
//   bytes only) matches.
//
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   imem_loader_if slave modport (stream in, IM write bus, status out)
//
//   ADDR_W  IM word-address width; capacity is 2**ADDR_W words (ADDR_W <= 16)
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // Largest legal length; widened by one bit so 2**16 would still fit.
  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

  // Running XOR checksum step.
  function automatic logic [7:0] csum_step(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

  // A length is rejected when it cannot fit in instruction memory.
  function automatic logic len_too_long(input logic [15:0] len);
    return ({1'b0, len} > CAPACITY);
  endfunction

  state_t            state_r, state_s;
  logic [15:0]       len_r, len_s;
  logic [15:0]       word_cnt_r, word_cnt_s;
  logic [1:0]        byte_cnt_r, byte_cnt_s;
  logic [23:0]       shift_r, shift_s;
  logic [7:0]        csum_r, csum_s;

  logic              in_ready_r, in_ready_s;
  logic              im_we_r, im_we_s;
  logic [ADDR_W-1:0] im_addr_r, im_addr_s;
  logic [31:0]       im_wdata_r, im_wdata_s;
  logic              cpu_rst_r, cpu_rst_s;
  logic              done_r, done_s;
  logic              err_r, err_s;

  logic              take_s;
  logic [15:0]       len_full_s;
  logic              last_word_s;

  // A byte moves only when the registered ready and the source's valid coincide.
  assign take_s      = bus.in_valid & in_ready_r;
  assign len_full_s  = {len_r[15:8], bus.in_data};
  assign last_word_s = (word_cnt_r == (len_r - 16'd1));

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    word_cnt_s = word_cnt_r;
    byte_cnt_s = byte_cnt_r;
    shift_s    = shift_r;
    csum_s     = csum_r;
    im_we_s    = 1'b0;
    im_addr_s  = im_addr_r;
    im_wdata_s = im_wdata_r;

    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        // start restarts a load; counters and checksum begin fresh.
        if (bus.start) begin
          state_s    = S_LEN_HI;
          len_s      = 16'd0;
          word_cnt_s = 16'd0;
          byte_cnt_s = 2'd0;
          shift_s    = 24'd0;
          csum_s     = 8'd0;
        end else begin
          state_s = state_r;
        end
      end

      S_LEN_HI: begin
        if (take_s) begin
          len_s   = {bus.in_data, 8'd0};
          state_s = S_LEN_LO;
        end else begin
          state_s = S_LEN_HI;
        end
      end

      S_LEN_LO: begin
        if (take_s) begin
          len_s = len_full_s;
          if (len_full_s == 16'd0) begin
            state_s = S_CHECK;
          end else if (len_too_long(len_full_s)) begin
            state_s = S_ERROR;
          end else begin
            state_s = S_DATA;
          end
        end else begin
          state_s = S_LEN_LO;
        end
      end

      S_DATA: begin
        if (take_s) begin
          csum_s = csum_step(csum_r, bus.in_data);
          if (byte_cnt_r == 2'd3) begin
            // Fourth byte completes the word; write it on the next cycle.
            im_we_s    = 1'b1;
            im_addr_s  = word_cnt_r[ADDR_W-1:0];
            im_wdata_s = {shift_r, bus.in_data};
            byte_cnt_s = 2'd0;
            shift_s    = 24'd0;
            word_cnt_s = word_cnt_r + 16'd1;
            if (last_word_s) begin
              state_s = S_CHECK;
            end else begin
              state_s = S_DATA;
            end
          end else begin
            shift_s    = {shift_r[15:0], bus.in_data};
            byte_cnt_s = byte_cnt_r + 2'd1;
          end
        end else begin
          state_s = S_DATA;
        end
      end

      S_CHECK: begin
        if (take_s) begin
          if (bus.in_data == csum_r) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ERROR;
          end
        end else begin
          state_s = S_CHECK;
        end
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Status outputs are a pure function of the state being entered, so they
    // change exactly one cycle after the event that caused the transition.
    in_ready_s = (state_s == S_LEN_HI) || (state_s == S_LEN_LO) ||
                 (state_s == S_DATA)   || (state_s == S_CHECK);
    cpu_rst_s  = (state_s != S_DONE);
    done_s     = (state_s == S_DONE);
    err_s      = (state_s == S_ERROR);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      len_r      <= 16'd0;
      word_cnt_r <= 16'd0;
      byte_cnt_r <= 2'd0;
      shift_r    <= 24'd0;
      csum_r     <= 8'd0;
      in_ready_r <= 1'b0;
      im_we_r    <= 1'b0;
      im_addr_r  <= '0;
      im_wdata_r <= 32'd0;
      cpu_rst_r  <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      word_cnt_r <= word_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      shift_r    <= shift_s;
      csum_r     <= csum_s;
      in_ready_r <= in_ready_s;
      im_we_r    <= im_we_s;
      im_addr_r  <= im_addr_s;
      im_wdata_r <= im_wdata_s;
      cpu_rst_r  <= cpu_rst_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.im_we    = im_we_r;
  assign bus.im_addr  = im_addr_r;
  assign bus.im_wdata = im_wdata_r;
  assign bus.cpu_rst  = cpu_rst_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Drives byte streams into imem_loader (ADDR_W=4, capacity 16 words) and
//   compares every cycle against a stream-level model: the model keeps the
//   bytes accepted so far and derives writes, status and ready from their
//   positions in the stream. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_imem_loader;
  localparam int AW  = 4;
  localparam int CAP = 16;

  typedef logic [7:0] bq_t[$];

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic clk;
  logic rst;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xor_of(input bq_t b, input int from, input int to);
    logic [7:0] x;
    x = 8'd0;
    for (int i = from; i <= to; i++) x = x ^ b[i];
    return x;
  endfunction

  // ---------------- model ----------------
  int            m_stat;
  bq_t           m_bytes;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];

  task automatic model_reset();
    m_stat  = M_IDLE;
    m_bytes.delete();
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = 32'd0;
  endtask

  initial model_reset();

  // Compare DUT against the model, then advance the model by this cycle's inputs.
  always @(negedge clk) begin
    int p;
    int n;
    if (rst) model_reset();
    chk("in_ready", 32'(bus.in_ready), 32'(m_stat == M_LOAD));
    chk("done",     32'(bus.done),     32'(m_stat == M_DONE));
    chk("err",      32'(bus.err),      32'(m_stat == M_ERR));
    chk("cpu_rst",  32'(bus.cpu_rst),  32'(m_stat != M_DONE));
    chk("im_we",    32'(bus.im_we),    32'(m_we));
    chk("im_addr",  32'(bus.im_addr),  32'(m_addr));
    chk("im_wdata", bus.im_wdata,      m_wdata);
    if (bus.im_we === 1'b1) begin
      log_addr.push_back(bus.im_addr);
      log_data.push_back(bus.im_wdata);
    end
    m_we = 1'b0;
    if (!rst) begin
      if (m_stat != M_LOAD && bus.start) begin
        m_stat = M_LOAD;
        m_bytes.delete();
      end else if (m_stat == M_LOAD && bus.in_valid) begin
        m_bytes.push_back(bus.in_data);
        p = m_bytes.size() - 1;
        if (p == 1) begin
          n = int'({m_bytes[0], m_bytes[1]});
          if (n > CAP) m_stat = M_ERR;
        end else if (p >= 2) begin
          n = int'({m_bytes[0], m_bytes[1]});
          if (p == 2 + 4 * n) begin
            m_stat = (xor_of(m_bytes, 2, p - 1) == bus.in_data) ? M_DONE : M_ERR;
          end else if ((p - 2) % 4 == 3) begin
            m_we    = 1'b1;
            m_addr  = AW'((p - 2) / 4);
            m_wdata = {m_bytes[p - 3], m_bytes[p - 2], m_bytes[p - 1], m_bytes[p]};
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse, with a decoy byte offered in the same cycle
  task automatic pulse_start();
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input bq_t b, input int gap_pct, input bit stray_start);
    int waited;
    foreach (b[i]) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.start    = stray_start && ($urandom_range(3) == 0);
        tick();
        bus.start    = 1'b0;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b[i];
      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 200) begin
        tick();
        waited++;
      end
      if (bus.in_ready !== 1'b1) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout actual=in_ready_low expected=in_ready_high byte=%0d", i);
        bus.in_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  bq_t t1;
  bq_t t2;
  bq_t s;

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    idle(3);
    chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    idle(2);

    t1 = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h21, 8'h10, 8'h20, 8'h31};
    t2 = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h21, 8'h10, 8'h20, 8'h30};
    chk("model_xor_t1", 32'(xor_of(t1, 2, 9)), 32'h31);

    // 1: nominal two-word load
    clear_log();
    pulse_start();
    send_bytes(t1, 0, 1'b0);
    chk("t1_done_next", 32'(bus.done), 32'd1);
    chk("t1_cpu_rst_next", 32'(bus.cpu_rst), 32'd0);
    idle(3);
    chk("t1_writes", 32'(log_data.size()), 32'd2);
    if (log_data.size() == 2) begin
      chk("t1_w0", log_data[0], 32'h24010005);
      chk("t1_a0", 32'(log_addr[0]), 32'd0);
      chk("t1_w1", log_data[1], 32'h00211020);
      chk("t1_a1", 32'(log_addr[1]), 32'd1);
    end

    // 2: bad checksum, restarted from DONE
    clear_log();
    pulse_start();
    chk("t2_cpu_rst_after_start", 32'(bus.cpu_rst), 32'd1);
    send_bytes(t2, 0, 1'b0);
    chk("t2_err", 32'(bus.err), 32'd1);
    chk("t2_done", 32'(bus.done), 32'd0);
    idle(3);
    chk("t2_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("t2_writes", 32'(log_data.size()), 32'd2);

    // 3: empty program
    clear_log();
    pulse_start();
    s = '{8'h00, 8'h00, 8'h00};
    send_bytes(s, 0, 1'b0);
    chk("t3_done", 32'(bus.done), 32'd1);
    chk("t3_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    idle(2);
    chk("t3_writes", 32'(log_data.size()), 32'd0);

    // 4: case 1 with valid gaps and ignored start pulses
    clear_log();
    pulse_start();
    send_bytes(t1, 40, 1'b1);
    idle(3);
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_writes", 32'(log_data.size()), 32'd2);
    if (log_data.size() == 2) begin
      chk("t4_w0", log_data[0], 32'h24010005);
      chk("t4_w1", log_data[1], 32'h00211020);
      chk("t4_a1", 32'(log_addr[1]), 32'd1);
    end

    // 5a: N=17 overflows 16-word memory
    clear_log();
    pulse_start();
    s = '{8'h00, 8'h11};
    send_bytes(s, 0, 1'b0);
    chk("t5a_err", 32'(bus.err), 32'd1);
    chk("t5a_in_ready", 32'(bus.in_ready), 32'd0);
    idle(3);
    chk("t5a_writes", 32'(log_data.size()), 32'd0);

    // 5b: N=16 exactly fills memory
    clear_log();
    pulse_start();
    s = '{8'h00, 8'h10};
    for (int i = 0; i < 64; i++) s.push_back(8'($urandom));
    s.push_back(xor_of(s, 2, 65));
    send_bytes(s, 10, 1'b0);
    chk("t5b_done", 32'(bus.done), 32'd1);
    idle(2);
    chk("t5b_writes", 32'(log_data.size()), 32'd16);
    if (log_addr.size() == 16) chk("t5b_last_addr", 32'(log_addr[15]), 32'd15);

    // 6: reset mid-load, rerun, restart from DONE
    clear_log();
    pulse_start();
    s = '{8'h00, 8'h02, 8'h24, 8'h01};
    send_bytes(s, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t6_rst_im_addr", 32'(bus.im_addr), 32'd0);
    chk("t6_rst_im_wdata", bus.im_wdata, 32'd0);
    chk("t6_rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    idle(2);
    rst = 1'b0;
    idle(2);
    chk("t6_no_writes", 32'(log_data.size()), 32'd0);
    pulse_start();
    send_bytes(t1, 0, 1'b0);
    idle(2);
    chk("t6_rerun_done", 32'(bus.done), 32'd1);
    chk("t6_rerun_writes", 32'(log_data.size()), 32'd2);
    pulse_start();
    chk("t6_restart_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("t6_restart_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t6_restart_done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);

    // random streams
    for (int it = 0; it < 30; it++) begin
      int  n;
      bit  good_cs;
      bit  expect_ok;
      logic [7:0] cs;
      n       = ($urandom_range(9) < 7) ? int'($urandom_range(CAP)) : int'($urandom_range(65535, CAP + 1));
      good_cs = ($urandom_range(3) != 0);
      s = '{8'(n >> 8), 8'(n)};
      if (n <= CAP) begin
        for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
        cs = xor_of(s, 2, 4 * n + 1);
        if (!good_cs) cs = cs ^ 8'($urandom_range(255, 1));
        s.push_back(cs);
      end
      expect_ok = (n <= CAP) && good_cs;
      clear_log();
      pulse_start();
      send_bytes(s, int'($urandom_range(50)), 1'b1);
      idle(2);
      chk("rand_done", 32'(bus.done), 32'(expect_ok));
      chk("rand_err", 32'(bus.err), 32'(!expect_ok));
      chk("rand_writes", 32'(log_data.size()), 32'((n <= CAP) ? n : 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
